// File: rtl/qpram_wr_sched_pkg.sv
// Shared types and sizing for the LUTRAM write scheduler.
// Entry layout, FSM states and pointer wrap helper.
package qpram_wr_sched_pkg;

  localparam int DEPTH  = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int DW     = 2;
  localparam int QDEPTH = 4;
  localparam int NRD    = 3;
  localparam int QPW    = $clog2(QDEPTH);
  localparam int QCW    = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_entry_t;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  function automatic logic [QPW-1:0] qwrap(
    input logic [QPW-1:0] p,
    input int             n
  );
    int s;
    s = int'(p) + n;
    return QPW'(s % QDEPTH);
  endfunction

endpackage

// File: rtl/qpram_wr_fifo.sv
// 2-in/1-out in-order write FIFO.
// Entries are exported oldest-first for the bypass search.
module qpram_wr_fifo
  import qpram_wr_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      push,
  input  wr_entry_t       din0,
  input  wr_entry_t       din1,
  input  logic            pop,
  output logic [QCW-1:0]  count,
  output logic [QCW-1:0]  free,
  output logic [QDEPTH-1:0] vld,
  output wr_entry_t       ent [QDEPTH]
);

  wr_entry_t      mem [QDEPTH];
  logic [QPW-1:0] wptr;
  logic [QPW-1:0] rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= qwrap(wptr, int'(push[0]) + int'(push[1]));
      if (pop)
        rptr <= qwrap(rptr, 1);
      count <= count + QCW'(push[0]) + QCW'(push[1])
             - QCW'(pop);
    end
  end

  // Channel 1 lands behind channel 0 when both push.
  always_ff @(posedge clk) begin
    if (push[0])
      mem[wptr] <= din0;
    if (push[1])
      mem[qwrap(wptr, int'(push[0]))] <= din1;
  end

  assign free = QCW'(QDEPTH) - count;

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      ent[i] = mem[qwrap(rptr, i)];
      vld[i] = QCW'(i) < count;
    end
  end

endmodule

// File: rtl/qpram_wr_sched.sv
// Write-port scheduler for 32-entry LUTRAM arrays: clear sweep,
// dual-channel enqueue, one commit per cycle, read bypass.
module qpram_wr_sched
  import qpram_wr_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wr_valid,
  output logic [1:0]        wr_ready,
  input  logic [2*AW-1:0]   wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  output logic              ram_we,
  output logic [AW-1:0]     ram_aw,
  output logic [DW-1:0]     ram_di,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_hit,
  output logic [NRD*DW-1:0] rd_data,
  output logic              init_done
);

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [1:0]      acc;
  logic            pop;
  logic [QCW-1:0]  q_count;
  logic [QCW-1:0]  q_free;
  logic [QDEPTH-1:0] q_vld;
  wr_entry_t       q_ent [QDEPTH];
  wr_entry_t       din0;
  wr_entry_t       din1;

  assign wr_ready[0] = init_done && (q_free >= QCW'(1));
  assign wr_ready[1] = init_done && (q_free >= QCW'(2));
  assign acc         = wr_valid & wr_ready;
  assign pop         = (state == RUN) && (q_count != '0);

  assign din0 = '{addr: wr_addr[0 +: AW], data: wr_data[0 +: DW]};
  assign din1 = '{addr: wr_addr[AW +: AW], data: wr_data[DW +: DW]};

  qpram_wr_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (acc),
    .din0  (din0),
    .din1  (din1),
    .pop   (pop),
    .count (q_count),
    .free  (q_free),
    .vld   (q_vld),
    .ent   (q_ent)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      cnt       <= '0;
      ram_we    <= 1'b0;
      ram_aw    <= '0;
      ram_di    <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          ram_we <= 1'b1;
          ram_aw <= cnt;
          ram_di <= '0;
          cnt    <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1))
            state <= RUN;
        end
        RUN: begin
          init_done <= 1'b1;
          ram_we    <= pop;
          if (pop) begin
            ram_aw <= q_ent[0].addr;
            ram_di <= q_ent[0].data;
          end
        end
      endcase
    end
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    logic [AW-1:0] a;
    logic          h;
    logic [DW-1:0] d;
    a       = '0;
    h       = 1'b0;
    d       = '0;
    rd_hit  = '0;
    rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      a = rd_addr[p*AW +: AW];
      h = 1'b0;
      d = '0;
      if (ram_we && ram_aw == a) begin
        h = 1'b1;
        d = ram_di;
      end
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_vld[i] && q_ent[i].addr == a) begin
          h = 1'b1;
          d = q_ent[i].data;
        end
      end
      rd_hit[p]          = h;
      rd_data[p*DW +: DW] = d;
    end
  end

endmodule

// File: tb/tb_qpram_wr_sched.sv
// Scoreboard bench for qpram_wr_sched against a queue-based model.
// Directed scenarios followed by a random phase.
module tb_qpram_wr_sched;
  import qpram_wr_sched_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        wr_valid;
  logic [1:0]        wr_ready;
  logic [2*AW-1:0]   wr_addr;
  logic [2*DW-1:0]   wr_data;
  logic              ram_we;
  logic [AW-1:0]     ram_aw;
  logic [DW-1:0]     ram_di;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD-1:0]    rd_hit;
  logic [NRD*DW-1:0] rd_data;
  logic              init_done;

  always #5 clk = ~clk;

  qpram_wr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ram_we    (ram_we),
    .ram_aw    (ram_aw),
    .ram_di    (ram_di),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .init_done (init_done)
  );

  int total = 0;
  int bad   = 0;

  wr_entry_t pend  [$];
  wr_entry_t exp_q [$];
  logic      owe;
  wr_entry_t oreg;
  int        cyc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit rdy_exp(int n);
    return (cyc >= DEPTH + 1) && (QDEPTH - pend.size() >= n);
  endfunction

  function automatic void byp(input logic [AW-1:0] a,
                              output bit h, output logic [DW-1:0] d);
    h = 0;
    d = '0;
    if (owe && oreg.addr == a) begin
      h = 1;
      d = oreg.data;
    end
    foreach (pend[i])
      if (pend[i].addr == a) begin
        h = 1;
        d = pend[i].data;
      end
  endfunction

  // Reference model: sweep, then FIFO queue of pending writes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      exp_q.delete();
      owe  = 0;
      oreg = '0;
      cyc  = 0;
      for (int k = 0; k < DEPTH; k++)
        exp_q.push_back('{addr: AW'(k), data: '0});
    end else begin
      bit a0, a1;
      a0 = wr_valid[0] && rdy_exp(1);
      a1 = wr_valid[1] && rdy_exp(2);
      if (cyc < DEPTH) begin
        owe  = 1;
        oreg = '{addr: AW'(cyc), data: '0};
      end else if (pend.size() > 0) begin
        owe  = 1;
        oreg = pend.pop_front();
      end else begin
        owe = 0;
      end
      if (a0) begin
        pend.push_back('{addr: wr_addr[0 +: AW], data: wr_data[0 +: DW]});
        exp_q.push_back('{addr: wr_addr[0 +: AW], data: wr_data[0 +: DW]});
      end
      if (a1) begin
        pend.push_back('{addr: wr_addr[AW +: AW], data: wr_data[DW +: DW]});
        exp_q.push_back('{addr: wr_addr[AW +: AW], data: wr_data[DW +: DW]});
      end
      cyc++;
    end
  end

  // Monitor: commits popped from the scoreboard, status vs model.
  always @(negedge clk) begin
    wr_entry_t     e;
    bit            h;
    logic [DW-1:0] d;
    chk("init_done", 32'(init_done), 32'(cyc >= DEPTH + 1));
    chk("wr_ready", 32'(wr_ready), 32'({rdy_exp(2), rdy_exp(1)}));
    chk("ram_we", 32'(ram_we), 32'(owe));
    if (ram_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL commit: got write %0h/%0h want none", ram_aw, ram_di);
      end else begin
        e = exp_q.pop_front();
        chk("ram_aw", 32'(ram_aw), 32'(e.addr));
        chk("ram_di", 32'(ram_di), 32'(e.data));
      end
    end
    for (int p = 0; p < NRD; p++) begin
      byp(rd_addr[p*AW +: AW], h, d);
      chk($sformatf("rd_hit%0d", p), 32'(rd_hit[p]), 32'(h));
      chk($sformatf("rd_data%0d", p), 32'(rd_data[p*DW +: DW]), 32'(d));
    end
  end

  task automatic step(input logic [1:0] v,
                      input int a0, input int d0,
                      input int a1, input int d1,
                      input int r0, input int r1, input int r2);
    @(posedge clk);
    #1;
    wr_valid = v;
    wr_addr  = {AW'(a1), AW'(a0)};
    wr_data  = {DW'(d1), DW'(d0)};
    rd_addr  = {AW'(r2), AW'(r1), AW'(r0)};
  endtask

  task automatic idle(input int n, input int r0, input int r1, input int r2);
    repeat (n) step(2'b00, 0, 0, 0, 0, r0, r1, r2);
  endtask

  initial begin
    wr_valid = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    @(negedge clk) rst_n = 1'b1;
    idle(DEPTH + 2, 0, 1, 2);

    step(2'b01, 5, 2, 0, 0, 5, 5, 5);
    idle(4, 5, 5, 5);

    step(2'b11, 7, 1, 7, 3, 7, 7, 9);
    idle(4, 7, 7, 9);

    for (int i = 0; i < 8; i++)
      step(2'b11, i, i, i + 8, 3 - (i % 4), i, i + 8, 3);
    idle(6, 1, 9, 7);

    step(2'b11, 10, 1, 11, 2, 10, 11, 12);
    step(2'b11, 12, 3, 13, 1, 10, 11, 12);
    idle(1, 10, 11, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst wr_ready", 32'(wr_ready), 32'd0);
    chk("rst init_done", 32'(init_done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(DEPTH + 2, 11, 12, 13);

    for (int i = 0; i < 1500; i++)
      step(2'($urandom), $urandom_range(0, 15), $urandom,
           $urandom_range(0, 15), $urandom,
           $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15));
    idle(10, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
